// File: rtl/ldr_avalon_ctrl.sv
// ldr_avalon_ctrl: Avalon-MM register file and run control for the LDR core
module ldr_avalon_ctrl #(
  parameter int ORDER = 10,
  parameter int WIDTH = 16,
  parameter int TO_DEFAULT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             readdatavalid,
  output logic             irq,
  output logic [7:0]       led,
  output logic             core_start,
  input  logic [4:0]       core_r_addr,
  output logic [WIDTH-1:0] core_r_data,
  input  logic             core_a_we,
  input  logic [4:0]       core_a_addr,
  input  logic [WIDTH-1:0] core_a_data,
  input  logic             core_done,
  input  logic             core_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [31:0] ID = 32'(ORDER * 256 + WIDTH);
  state_t state, state_n;
  logic srst, irq_en, err, tmo, collide;
  logic [WIDTH-1:0] to_reg, cnt, rd_r, rd_a, rd_mux;
  logic [WIDTH-1:0] r [ORDER+1];
  logic [WIDTH-1:0] a [ORDER+1];
  logic wr_ctrl, w1c, srst_n, start_req, go, r_hit, coll, fin;
  assign wr_ctrl = write && address == 8'h00;
  assign w1c = write && address == 8'h01 && writedata[1];
  assign srst_n = wr_ctrl ? writedata[0] : srst;
  assign start_req = wr_ctrl && writedata[1] && !writedata[0];
  assign go = start_req && state != RUN;
  assign r_hit = write && address[7:5] == 3'b001 && address[4:0] <= 5'(ORDER);
  assign coll = state == RUN && (start_req || r_hit);
  assign fin = state == RUN && (core_done || (to_reg != '0 && cnt == to_reg - 1'b1));
  assign led = {5'b0, err, state == DONE, state == RUN};
  always_comb begin
    state_n = srst_n ? IDLE : go ? RUN : fin ? DONE : (state == DONE && w1c) ? IDLE : state;
  end
  always_comb begin
    rd_r = '0;
    rd_a = '0;
    core_r_data = '0;
    for (int i = 0; i <= ORDER; i++) begin
      rd_r = address[4:0] == 5'(i) ? r[i] : rd_r;
      rd_a = address[4:0] == 5'(i) ? a[i] : rd_a;
      core_r_data = core_r_addr == 5'(i) ? r[i] : core_r_data;
    end
    rd_mux = address == 8'h00 ? WIDTH'({irq_en, 1'b0, srst}) :
             address == 8'h01 ? WIDTH'({collide, tmo, err, state == DONE, state == RUN}) :
             address == 8'h02 ? to_reg :
             address == 8'h03 ? ID[WIDTH-1:0] :
             address[7:5] == 3'b001 ? rd_r :
             address[7:5] == 3'b010 ? rd_a : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      srst <= 1'b0;
      irq_en <= 1'b0;
      err <= 1'b0;
      tmo <= 1'b0;
      collide <= 1'b0;
      to_reg <= WIDTH'(TO_DEFAULT);
      cnt <= '0;
      core_start <= 1'b0;
      irq <= 1'b0;
      readdata <= '0;
      readdatavalid <= 1'b0;
      for (int i = 0; i <= ORDER; i++) begin
        r[i] <= '0;
        a[i] <= '0;
      end
    end else begin
      state <= state_n;
      core_start <= go;
      cnt <= go ? '0 : state == RUN ? cnt + 1'b1 : cnt;
      irq <= irq_en && state == DONE;
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (wr_ctrl) begin
        srst <= writedata[0];
        irq_en <= writedata[2];
      end
      if (write && address == 8'h02) to_reg <= writedata;
      err <= (srst_n || go) ? 1'b0 : fin ? core_done && core_err : w1c ? 1'b0 : err;
      tmo <= (srst_n || go) ? 1'b0 : fin ? !core_done : w1c ? 1'b0 : tmo;
      collide <= (srst_n || go) ? 1'b0 : coll ? 1'b1 : w1c ? 1'b0 : collide;
      for (int i = 0; i <= ORDER; i++) begin
        if (r_hit && state != RUN && address[4:0] == 5'(i)) r[i] <= writedata;
        a[i] <= srst_n ? '0 : (state == RUN && core_a_we && core_a_addr == 5'(i)) ? core_a_data : a[i];
      end
    end
  end
endmodule

// File: doc/ldr_avalon_ctrl.md
# ldr_avalon_ctrl

Parametrised Avalon-MM slave front end for the Levinson-Durbin recursion (LDR) core. It replaces the fixed order-10, 16-bit register wrapper with a generic ORDER/WIDTH register file and a run-control state machine. The run control provides a self-clearing start, sticky status, a timeout watchdog, a maskable interrupt and collision detection. It sits between the Nios/Avalon fabric and the LDR core: it feeds the autocorrelation bank R to the core and captures the predictor coefficients A written back by the core.

## Interface
- ORDER, 10: predictor order; R and A banks hold ORDER+1 words each (1..31)
- WIDTH, 16: data width of bus and banks (8..32)
- TO_DEFAULT, 4096: reset value of the TIMEOUT register
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- address  in  8  word address
- read  in  1  bus read strobe
- write  in  1  bus write strobe
- writedata  in  WIDTH  bus write data
- readdata  out  WIDTH  read data, valid with readdatavalid
- readdatavalid  out  1  one-cycle pulse, one cycle after read
- irq  out  1  level interrupt = IRQ_EN & DONE
- led  out  8  {5'b0, err, done, busy}
- core_start  out  1  one-cycle start pulse to the LDR core
- core_r_addr  in  5  R bank index requested by the core
- core_r_data  out  WIDTH  R[core_r_addr], combinational; 0 if the index exceeds ORDER
- core_a_we  in  1  coefficient write strobe from the core
- core_a_addr  in  5  coefficient index
- core_a_data  in  WIDTH  coefficient value
- core_done  in  1  core completion pulse
- core_err  in  1  core instability flag (|k|>=1), sampled with core_done

## Operation
- Register map (word addresses):
  - 0x00 CTRL (R/W): bit0 SRST (level), bit1 START (write-1 pulse, reads 0), bit2 IRQ_EN.
  - 0x01 STATUS: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TIMEOUT, bit4 COLLIDE. Writing 1 to bit1 clears DONE, ERR, TIMEOUT and COLLIDE; other bits are read-only.
  - 0x02 TIMEOUT (R/W, cycles; 0 disables the watchdog).
  - 0x03 ID (RO): {ORDER, WIDTH} packed as ORDER in [15:8], WIDTH in [7:0].
  - 0x20+i R[i] (R/W), i=0..ORDER.
  - 0x40+i A[i] (RO), i=0..ORDER.
  - Unmapped or out-of-range reads return 0; writes to them are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: START written with SRST=0. core_start is high for exactly the cycle after the write. The watchdog counter is cleared. BUSY=1.
  - RUN→DONE on core_done: DONE=1, ERR=core_err, BUSY=0.
  - RUN→DONE when the watchdog counter reaches a nonzero TIMEOUT: DONE=1, TIMEOUT=1, BUSY=0.
  - DONE→IDLE on a W1C of STATUS.bit1.
  - DONE→RUN on START; the status flags are cleared and a new run begins.
- A bank: written only when the state is RUN, core_a_we=1 and core_a_addr<=ORDER; otherwise the write is ignored.
- Collisions: in RUN, bus writes to the R bank and START writes are ignored and set COLLIDE.
- SRST=1: forces IDLE, clears STATUS and the A bank, blocks START, suppresses core_start. R, TIMEOUT and IRQ_EN are retained.
- rst: clears everything. TIMEOUT=TO_DEFAULT, R=0, A=0, CTRL=0, state IDLE.
- Every output resets to 0 except core_r_data (tracks R, so 0 after reset).
- Widths: registers are WIDTH bits. CTRL, STATUS and ID are zero-extended. writedata bits above WIDTH do not exist; no sign extension inside the block.

## Timing
- Read latency is fixed at 1. readdata is registered and held until the next read. read and write in the same cycle: the write is performed, and the read returns the pre-write value.
- Register writes take effect on the clock edge with write=1 and are visible to a read issued on the next cycle.
- Watchdog: a counter increments every RUN cycle starting with the core_start cycle. Timeout fires on the cycle count==TIMEOUT.
- Simultaneous events:
  - core_done and timeout in the same cycle: core_done wins, TIMEOUT=0.
  - W1C and a DONE-setting event in the same cycle: set wins.
  - SRST and START in the same write: SRST wins.
  - core_a_we on the core_done cycle: the write is accepted.
- irq asserts the cycle after DONE sets (registered) if IRQ_EN=1. It deasserts the cycle after DONE clears or IRQ_EN is written to 0.

## Test plan
- Reset and identification:
  - Stimulus: rst for 2 cycles, then read 0x01, 0x02, 0x03.
  - Required: readdata 0, TO_DEFAULT, 0x0A10; readdatavalid exactly 1 cycle after each read; irq=0, led=0.
- Normal run:
  - Stimulus: load R0..R10 = 32767, 25742, 16169, 9836, 4569, -2674, -11249, -17338, -14853, -6828, -3174. Write CTRL=0x6. The bench core model reads R via core_r_addr, writes A[i]=i*100, then pulses core_done after 50 cycles.
  - Required: core_start is a single pulse. STATUS reads 0x1 during the run and 0x2 after. irq=1. A[3] reads 300.
- Collision:
  - Stimulus: during RUN, write R[2]=1 and write START.
  - Required: R[2] still reads 16169; STATUS.COLLIDE=1; no second core_start.
- Timeout:
  - Stimulus: TIMEOUT=20; core never asserts core_done.
  - Required: DONE=1 and TIMEOUT=1 at cycle 20 after core_start; BUSY=0.
- Clear and restart:
  - Stimulus: W1C STATUS=0x2; confirm irq drops. Then START with core_err=1 at done.
  - Required: STATUS=0x6 after the second run.
- Soft reset mid-run:
  - Stimulus: CTRL=0x1 during RUN.
  - Required: next cycle state is IDLE; STATUS=0; A bank reads 0; R bank unchanged; START is ignored while SRST=1.
